// File: rtl/control_sequencer_if.sv
// Control bundle between the mini-SRC sequencer (master) and the System datapath (slave).
// Carries the instruction register and every datapath strobe.
interface control_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPCODE_W   = 5
);
  logic [DATA_WIDTH-1:0] IR;
  logic PCout, IncPC, PCin;
  logic MARin, MDRin, MDRout, IRin;
  logic Zin, Zlo_out, Yin, Cout;
  logic Gra, Grb, Rin, Rout, BAout;
  logic HIout, LOout;
  logic Mem_Read, Mem_Write, Mem_enable512x32;
  logic [OPCODE_W-1:0] opcode;
  logic Run;

  modport master (
    input  IR,
    output PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
    output Zin, Zlo_out, Yin, Cout, Gra, Grb, Rin, Rout, BAout,
    output HIout, LOout, Mem_Read, Mem_Write, Mem_enable512x32, opcode, Run
  );

  modport slave (
    output IR,
    input  PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
    input  Zin, Zlo_out, Yin, Cout, Gra, Grb, Rin, Rout, BAout,
    input  HIout, LOout, Mem_Read, Mem_Write, Mem_enable512x32, opcode, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for mini-SRC: fetch T0-T2, execute T3-T7, outputs decoded from state and IR[31:27].
// Optional single-step mode: define CTRL_SINGLE_STEP_EN to add the Step input and the WAIT state.
module control_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OPCODE_W   = 5
) (
  input  logic Clock,
  input  logic clear,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic Step,
`endif
  control_sequencer_if.master bus
);

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [OPCODE_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [OPCODE_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OPCODE_W-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CTRL_SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_t;

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t S_DONE = S_WAIT;
`else
  localparam state_t S_DONE = S_T0;
`endif

  state_t state;

  logic [OPCODE_W-1:0] op;
  logic is_alu, is_ldi, is_ld, is_st, is_mem, uses_imm;
  logic [OPCODE_W-1:0] alu_code;

  // IR is stable from T3 until the next T2, so execute states decode it directly.
  assign op       = bus.IR[DATA_WIDTH-1 -: OPCODE_W];
  assign is_alu   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_ldi   = (op == OP_LDI);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_mem   = is_ld || is_st;
  assign uses_imm = is_alu || is_ldi || is_mem;

  always_comb begin
    alu_code = ALU_ADD;
    if (op == OP_ANDI)     alu_code = ALU_AND;
    else if (op == OP_ORI) alu_code = ALU_OR;
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:  state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          if (op == OP_HALT)  state <= S_HALT;
          else if (uses_imm)  state <= S_T4;
          else                state <= S_DONE;
        end
        S_T4:   state <= S_T5;
        S_T5:   state <= is_mem ? S_T6 : S_DONE;
        S_T6:   state <= S_T7;
        S_T7:   state <= S_DONE;
        S_HALT: state <= S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
        S_WAIT: state <= Step ? S_T0 : S_WAIT;
`endif
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    bus.PCout = 1'b0;  bus.IncPC = 1'b0;  bus.PCin = 1'b0;
    bus.MARin = 1'b0;  bus.MDRin = 1'b0;  bus.MDRout = 1'b0;  bus.IRin = 1'b0;
    bus.Zin = 1'b0;    bus.Zlo_out = 1'b0; bus.Yin = 1'b0;    bus.Cout = 1'b0;
    bus.Gra = 1'b0;    bus.Grb = 1'b0;    bus.Rin = 1'b0;     bus.Rout = 1'b0;
    bus.BAout = 1'b0;  bus.HIout = 1'b0;  bus.LOout = 1'b0;
    bus.Mem_Read = 1'b0; bus.Mem_Write = 1'b0; bus.Mem_enable512x32 = 1'b0;
    bus.opcode = '0;
    bus.Run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlo_out = 1'b1; bus.PCin = 1'b1; bus.MDRin = 1'b1;
        bus.Mem_Read = 1'b1; bus.Mem_enable512x32 = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (uses_imm) begin
          // ALU-immediate reads Rb; ld/ldi/st use the base-address path so r0 reads as zero.
          bus.Grb = 1'b1; bus.Yin = 1'b1;
          bus.Rout = is_alu; bus.BAout = !is_alu;
        end else if (op == OP_MFHI) begin
          bus.Gra = 1'b1; bus.HIout = 1'b1; bus.Rin = 1'b1;
        end else if (op == OP_MFLO) begin
          bus.Gra = 1'b1; bus.LOout = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T4: begin
        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = alu_code;
      end
      S_T5: begin
        bus.Zlo_out = 1'b1;
        if (is_mem) bus.MARin = 1'b1;
        else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (is_ld) begin
          bus.Mem_Read = 1'b1; bus.Mem_enable512x32 = 1'b1;
        end else begin
          bus.Gra = 1'b1; bus.Rout = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else begin
          bus.Mem_Write = 1'b1; bus.Mem_enable512x32 = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
